// File: rtl/rob_mc.sv
// rob_mc: parametrised reorder buffer. Allocates in program order, takes
// results from NUM_CDB broadcast channels, offers operand lookup with
// same-cycle bypass, retires one entry per cycle and flushes on mispredict.
module rob_mc #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_rd,
    input  logic [WIDTH-1:0]         alloc_pc,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*WIDTH-1:0] cdb_data,
    input  logic [NUM_CDB-1:0]       cdb_mispredict,
    input  logic [NUM_CDB*WIDTH-1:0] cdb_target,
    input  logic [TAG_W-1:0]         rs1_tag,
    input  logic [TAG_W-1:0]         rs2_tag,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [WIDTH-1:0]         rs1_data,
    output logic [WIDTH-1:0]         rs2_data,
    output logic                     commit_valid,
    output logic [4:0]               commit_rd,
    output logic [WIDTH-1:0]         commit_data,
    output logic [TAG_W-1:0]         commit_tag,
    output logic                     flush,
    output logic [WIDTH-1:0]         flush_pc,
    output logic [TAG_W:0]           count,
    output logic                     empty,
    output logic                     full
);

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    // Per-entry status bits live in flops with reset; payload lives in plain storage.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_done;
    logic [DEPTH-1:0] ent_mis;
    logic [4:0]       ent_rd     [DEPTH];
    logic [WIDTH-1:0] ent_data   [DEPTH];
    logic [WIDTH-1:0] ent_pc     [DEPTH];
    logic [WIDTH-1:0] ent_target [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;

    logic [TAG_W-1:0] ch_tag    [NUM_CDB];
    logic [WIDTH-1:0] ch_data   [NUM_CDB];
    logic [WIDTH-1:0] ch_target [NUM_CDB];
    logic [NUM_CDB-1:0] ch_hit;
    logic alloc_fire;

    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign alloc_ready = !full && !flush;
    assign alloc_tag   = tail;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign commit_valid = ent_valid[head] && ent_done[head];
    assign commit_rd    = commit_valid ? ent_rd[head]   : '0;
    assign commit_data  = commit_valid ? ent_data[head] : '0;
    assign commit_tag   = commit_valid ? head           : '0;
    assign flush        = commit_valid && ent_mis[head];
    assign flush_pc     = flush ? ent_target[head] : '0;

    // Unpack the broadcast buses and decide which channels land on a waiting entry.
    always_comb begin
        for (int i = 0; i < NUM_CDB; i++) begin
            ch_tag[i]    = cdb_tag[i*TAG_W +: TAG_W];
            ch_data[i]   = cdb_data[i*WIDTH +: WIDTH];
            ch_target[i] = cdb_target[i*WIDTH +: WIDTH];
            ch_hit[i]    = cdb_valid[i] && ent_valid[ch_tag[i]] && !ent_done[ch_tag[i]];
        end
    end

    // Operand lookup: stored result first, else same-cycle bypass, lowest channel wins.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so later writes override earlier ones and no latch forms.
        rs1_ready = 1'b0;
        rs1_data  = '0;
        rs2_ready = 1'b0;
        rs2_data  = '0;
        for (int i = NUM_CDB-1; i >= 0; i--) begin
            if (cdb_valid[i] && ch_tag[i] == rs1_tag) begin
                rs1_ready = 1'b1;
                rs1_data  = ch_data[i];
            end
            if (cdb_valid[i] && ch_tag[i] == rs2_tag) begin
                rs2_ready = 1'b1;
                rs2_data  = ch_data[i];
            end
        end
        if (ent_valid[rs1_tag] && ent_done[rs1_tag]) begin
            rs1_ready = 1'b1;
            rs1_data  = ent_data[rs1_tag];
        end
        if (ent_valid[rs2_tag] && ent_done[rs2_tag]) begin
            rs2_ready = 1'b1;
            rs2_data  = ent_data[rs2_tag];
        end
    end

    // Pointers, occupancy and entry status: allocate, complete, retire, flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_mis   <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                ent_mis[tail]   <= 1'b0;
                tail            <= tail + TAG_W'(1);
            end
            // NOTE: walking channels high-to-low lets the lowest index issue the
            // last non-blocking write, so it wins when two channels share a tag.
            for (int i = NUM_CDB-1; i >= 0; i--) begin
                if (ch_hit[i]) begin
                    ent_done[ch_tag[i]] <= 1'b1;
                    ent_mis[ch_tag[i]]  <= cdb_mispredict[i];
                end
            end
            if (commit_valid) begin
                ent_valid[head] <= 1'b0;
                head            <= head + TAG_W'(1);
            end
            case ({alloc_fire, commit_valid})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload capture on allocation and on a landing broadcast.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; it is only ever read behind a
        // valid/done bit, which is reset, so clearing it would be wasted logic.
        if (alloc_fire) begin
            ent_rd[tail] <= alloc_rd;
            ent_pc[tail] <= alloc_pc;
        end
        for (int i = NUM_CDB-1; i >= 0; i--) begin
            if (!flush && ch_hit[i]) begin
                ent_data[ch_tag[i]]   <= ch_data[i];
                ent_target[ch_tag[i]] <= ch_target[i];
            end
        end
    end

endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed scenarios plus randomized traffic for rob_mc, checked
// against a queue-based program-order model of the reorder buffer.
module tb_rob_mc;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int NC = 2;
    localparam int TW = 3;

    logic           clk;
    logic           rst;
    logic           alloc_valid;
    logic [4:0]     alloc_rd;
    logic [W-1:0]   alloc_pc;
    logic           alloc_ready;
    logic [TW-1:0]  alloc_tag;
    logic [NC-1:0]  cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*W-1:0]  cdb_data;
    logic [NC-1:0]  cdb_mispredict;
    logic [NC*W-1:0]  cdb_target;
    logic [TW-1:0]  rs1_tag, rs2_tag;
    logic           rs1_ready, rs2_ready;
    logic [W-1:0]   rs1_data, rs2_data;
    logic           commit_valid;
    logic [4:0]     commit_rd;
    logic [W-1:0]   commit_data;
    logic [TW-1:0]  commit_tag;
    logic           flush;
    logic [W-1:0]   flush_pc;
    logic [TW:0]    count;
    logic           empty, full;

    int vectors = 0;
    int errors  = 0;

    rob_mc #(.WIDTH(W), .DEPTH(D), .NUM_CDB(NC)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .flush(flush), .flush_pc(flush_pc),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Occupied tags in program order; the head of the ROB is q[0].
    int           q[$];
    int           next_tag;
    logic         m_done [D];
    logic         m_mis  [D];
    logic [4:0]   m_rd   [D];
    logic [W-1:0] m_data [D];
    logic [W-1:0] m_tgt  [D];

    logic         exp_cv, exp_flush, exp_ready, exp_empty, exp_full;
    logic [4:0]   exp_crd;
    logic [W-1:0] exp_cdata, exp_fpc;
    int           exp_ctag, exp_count, exp_atag;
    logic         exp_r1, exp_r2;
    logic [W-1:0] exp_d1, exp_d2;

    function automatic bit in_rob(int t);
        foreach (q[k]) if (q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic lookup(input int t, output logic r, output logic [W-1:0] d);
        r = 1'b0;
        d = '0;
        if (in_rob(t) && m_done[t]) begin
            r = 1'b1;
            d = m_data[t];
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (!r && cdb_valid[c] && int'(cdb_tag[c*TW +: TW]) == t) begin
                    r = 1'b1;
                    d = cdb_data[c*W +: W];
                end
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_tag = 0;
        for (int k = 0; k < D; k++) begin
            m_done[k] = 1'b0;
            m_mis[k]  = 1'b0;
        end
    endtask

    task automatic model_eval();
        exp_count = q.size();
        exp_empty = (q.size() == 0);
        exp_full  = (q.size() == D);
        exp_cv    = (q.size() > 0) && m_done[q[0]];
        exp_ctag  = exp_cv ? q[0] : 0;
        exp_crd   = exp_cv ? m_rd[q[0]] : 5'd0;
        exp_cdata = exp_cv ? m_data[q[0]] : '0;
        exp_flush = exp_cv && m_mis[q[0]];
        exp_fpc   = exp_flush ? m_tgt[q[0]] : '0;
        exp_ready = !exp_full && !exp_flush;
        exp_atag  = next_tag;
        lookup(int'(rs1_tag), exp_r1, exp_d1);
        lookup(int'(rs2_tag), exp_r2, exp_d2);
    endtask

    task automatic model_step();
        int t;
        model_eval();
        if (exp_flush) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NC; c++) begin
            t = int'(cdb_tag[c*TW +: TW]);
            if (cdb_valid[c] && in_rob(t) && !m_done[t]) begin
                m_done[t] = 1'b1;
                m_mis[t]  = cdb_mispredict[c];
                m_data[t] = cdb_data[c*W +: W];
                m_tgt[t]  = cdb_target[c*W +: W];
            end
        end
        if (exp_cv) void'(q.pop_front());
        if (alloc_valid && exp_ready) begin
            q.push_back(next_tag);
            m_done[next_tag] = 1'b0;
            m_mis[next_tag]  = 1'b0;
            m_rd[next_tag]   = alloc_rd;
            next_tag = (next_tag + 1) % D;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_cdb();
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        cdb_mispredict = '0; cdb_target = '0;
    endtask

    task automatic set_cdb(input int c, input int tag, input logic [W-1:0] data,
                           input logic mis, input logic [W-1:0] tgt);
        cdb_valid[c] = 1'b1;
        cdb_tag[c*TW +: TW] = TW'(tag);
        cdb_data[c*W +: W] = data;
        cdb_mispredict[c] = mis;
        cdb_target[c*W +: W] = tgt;
    endtask

    task automatic clear_inputs();
        alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0;
        rs1_tag = '0; rs2_tag = '0;
        clear_cdb();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_rd = 5'(i + 1);
            alloc_pc = 32'h1000 + 32'(4*i);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        vectors++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin errors++;
            $display("FAIL reset_alloc: ready=%b tag=%0d expected ready=1 tag=0", alloc_ready, alloc_tag); end
        vectors++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin errors++;
            $display("FAIL reset_occupancy: empty=%b full=%b count=%0d expected 1 0 0", empty, full, count); end
        vectors++; if (commit_valid !== 1'b0 || flush !== 1'b0 || flush_pc !== 32'd0) begin errors++;
            $display("FAIL reset_commit: cv=%b flush=%b fpc=%h expected 0 0 0", commit_valid, flush, flush_pc); end
        vectors++; if (rs1_ready !== 1'b0 || rs2_ready !== 1'b0) begin errors++;
            $display("FAIL reset_lookup: rs1_ready=%b rs2_ready=%b expected 0 0", rs1_ready, rs2_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_drain_wrap();
        do_reset();
        for (int i = 0; i < D; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_pc = 32'(i);
            #1;
            vectors++; if (alloc_tag !== TW'(i) || alloc_ready !== 1'b1) begin errors++;
                $display("FAIL fill_tag: tag=%0d ready=%b expected tag=%0d ready=1", alloc_tag, alloc_ready, i); end
            tick();
        end
        alloc_valid = 1'b1; alloc_rd = 5'd31;
        #1;
        vectors++; if (full !== 1'b1 || count !== 4'd8 || alloc_ready !== 1'b0) begin errors++;
            $display("FAIL fill_full: full=%b count=%0d ready=%b expected 1 8 0", full, count, alloc_ready); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++; if (alloc_tag !== 3'd0 || count !== 4'd8) begin errors++;
            $display("FAIL fill_refused: tag=%0d count=%0d expected 0 8", alloc_tag, count); end
        for (int p = 0; p < 4; p++) begin
            set_cdb(0, 7 - 2*p, 32'h100 + 32'(7 - 2*p), 1'b0, '0);
            set_cdb(1, 6 - 2*p, 32'h100 + 32'(6 - 2*p), 1'b0, '0);
            #1;
            vectors++; if (commit_valid !== 1'b0) begin errors++;
                $display("FAIL drain_early: commit_valid=%b expected 0 at pair %0d", commit_valid, p); end
            tick();
        end
        clear_cdb();
        for (int k = 0; k < D; k++) begin
            #1;
            vectors++; if (commit_valid !== 1'b1 || commit_tag !== TW'(k) ||
                           commit_data !== 32'h100 + 32'(k) || commit_rd !== 5'(k + 1)) begin errors++;
                $display("FAIL drain_order: cv=%b tag=%0d data=%h rd=%0d expected 1 %0d %h %0d",
                         commit_valid, commit_tag, commit_data, commit_rd, k, 32'h100 + 32'(k), k + 1); end
            tick();
        end
        #1;
        vectors++; if (empty !== 1'b1) begin errors++;
            $display("FAIL drain_empty: empty=%b expected 1", empty); end
        for (int i = 0; i < D; i++) begin
            alloc_valid = 1'b1;
            #1;
            vectors++; if (alloc_tag !== TW'(i)) begin errors++;
                $display("FAIL wrap_tag: tag=%0d expected %0d", alloc_tag, i); end
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_dual_channel();
        do_reset();
        alloc_n(3);
        set_cdb(0, 1, 32'hAAAA_0001, 1'b0, '0);
        set_cdb(1, 2, 32'hBBBB_0002, 1'b0, '0);
        tick();
        clear_cdb();
        rs1_tag = 3'd1; rs2_tag = 3'd2;
        set_cdb(0, 0, 32'h0000_00C0, 1'b0, '0);
        #1;
        vectors++; if (rs1_ready !== 1'b1 || rs1_data !== 32'hAAAA_0001 ||
                       rs2_ready !== 1'b1 || rs2_data !== 32'hBBBB_0002) begin errors++;
            $display("FAIL dual_done: r1=%b d1=%h r2=%b d2=%h expected 1 aaaa0001 1 bbbb0002",
                     rs1_ready, rs1_data, rs2_ready, rs2_data); end
        vectors++; if (commit_valid !== 1'b0) begin errors++;
            $display("FAIL dual_head_wait: cv=%b expected 0", commit_valid); end
        tick();
        clear_cdb();
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (commit_valid !== 1'b1 || commit_tag !== TW'(k) || commit_data !== exp_cdata_dual(k)) begin
                errors++;
                $display("FAIL dual_commit: cv=%b tag=%0d data=%h expected 1 %0d %h",
                         commit_valid, commit_tag, commit_data, k, exp_cdata_dual(k)); end
            tick();
        end
    endtask

    function automatic logic [W-1:0] exp_cdata_dual(int k);
        case (k)
            0: return 32'h0000_00C0;
            1: return 32'hAAAA_0001;
            default: return 32'hBBBB_0002;
        endcase
    endfunction

    task automatic test_bypass();
        do_reset();
        alloc_n(4);
        rs1_tag = 3'd3;
        #1;
        vectors++; if (rs1_ready !== 1'b0 || rs1_data !== 32'd0) begin errors++;
            $display("FAIL bypass_idle: r=%b d=%h expected 0 0", rs1_ready, rs1_data); end
        set_cdb(1, 3, 32'h1234, 1'b0, '0);
        #1;
        vectors++; if (rs1_ready !== 1'b1 || rs1_data !== 32'h1234) begin errors++;
            $display("FAIL bypass_same_cycle: r=%b d=%h expected 1 1234", rs1_ready, rs1_data); end
        tick();
        clear_cdb();
        #1;
        vectors++; if (rs1_ready !== 1'b1 || rs1_data !== 32'h1234) begin errors++;
            $display("FAIL bypass_stored: r=%b d=%h expected 1 1234", rs1_ready, rs1_data); end
        rs2_tag = 3'd2;
        set_cdb(0, 2, 32'h2222, 1'b0, '0);
        set_cdb(1, 2, 32'h3333, 1'b0, '0);
        #1;
        vectors++; if (rs2_ready !== 1'b1 || rs2_data !== 32'h2222) begin errors++;
            $display("FAIL bypass_priority: r=%b d=%h expected 1 2222", rs2_ready, rs2_data); end
        tick();
        clear_cdb();
        #1;
        vectors++; if (rs2_ready !== 1'b1 || rs2_data !== 32'h2222) begin errors++;
            $display("FAIL store_priority: r=%b d=%h expected 1 2222", rs2_ready, rs2_data); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5);
        set_cdb(0, 1, 32'h11, 1'b0, '0); set_cdb(1, 2, 32'h22, 1'b0, '0);
        tick();
        set_cdb(0, 3, 32'h33, 1'b0, '0); set_cdb(1, 4, 32'h44, 1'b0, '0);
        tick();
        clear_cdb();
        set_cdb(0, 0, 32'h5A, 1'b1, 32'h0000_0100);
        #1;
        vectors++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin errors++;
            $display("FAIL flush_early: cv=%b flush=%b expected 0 0", commit_valid, flush); end
        tick();
        clear_cdb();
        alloc_valid = 1'b1;
        #1;
        vectors++; if (commit_valid !== 1'b1 || commit_tag !== 3'd0 || commit_data !== 32'h5A ||
                       flush !== 1'b1 || flush_pc !== 32'h100 || alloc_ready !== 1'b0) begin errors++;
            $display("FAIL flush_cycle: cv=%b tag=%0d data=%h flush=%b fpc=%h ready=%b expected 1 0 5a 1 100 0",
                     commit_valid, commit_tag, commit_data, flush, flush_pc, alloc_ready); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++; if (empty !== 1'b1 || count !== 4'd0 || alloc_tag !== 3'd0 ||
                       flush !== 1'b0 || commit_valid !== 1'b0) begin errors++;
            $display("FAIL flush_after: empty=%b count=%0d tag=%0d flush=%b cv=%b expected 1 0 0 0 0",
                     empty, count, alloc_tag, flush, commit_valid); end
        alloc_n(1);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (commit_valid !== 1'b0 || count !== 4'd1) begin errors++;
                $display("FAIL flush_no_stale: cv=%b count=%0d expected 0 1", commit_valid, count); end
            tick();
        end
    endtask

    task automatic test_alloc_commit();
        do_reset();
        alloc_n(4);
        set_cdb(0, 0, 32'h55, 1'b0, '0);
        tick();
        clear_cdb();
        alloc_valid = 1'b1;
        #1;
        vectors++; if (commit_valid !== 1'b1 || count !== 4'd4 || alloc_tag !== 3'd4) begin errors++;
            $display("FAIL simul_before: cv=%b count=%0d tag=%0d expected 1 4 4", commit_valid, count, alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++; if (count !== 4'd4 || alloc_tag !== 3'd5) begin errors++;
            $display("FAIL simul_after: count=%0d tag=%0d expected 4 5", count, alloc_tag); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(6);
        set_cdb(0, 0, 32'h77, 1'b0, '0);
        tick();
        clear_cdb();
        #1;
        vectors++; if (commit_valid !== 1'b1 || count !== 4'd6) begin errors++;
            $display("FAIL areset_pre: cv=%b count=%0d expected 1 6", commit_valid, count); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || alloc_tag !== 3'd0 ||
                       alloc_ready !== 1'b1 || commit_valid !== 1'b0 || flush !== 1'b0) begin errors++;
            $display("FAIL areset_now: count=%0d empty=%b full=%b tag=%0d ready=%b cv=%b flush=%b expected 0 1 0 0 1 0 0",
                     count, empty, full, alloc_tag, alloc_ready, commit_valid, flush); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int t;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            alloc_valid = ($urandom_range(0, 99) < 60);
            alloc_rd = 5'($urandom);
            alloc_pc = $urandom;
            clear_cdb();
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 99) < 50) begin
                    if (q.size() > 0 && $urandom_range(0, 9) < 8) t = q[$urandom_range(0, q.size() - 1)];
                    else t = $urandom_range(0, D - 1);
                    set_cdb(c, t, $urandom, ($urandom_range(0, 19) == 0), $urandom);
                end
            end
            rs1_tag = 3'($urandom); rs2_tag = 3'($urandom);
            #1;
            model_eval();
            vectors++; if (count !== 4'(exp_count) || empty !== exp_empty || full !== exp_full) begin errors++;
                $display("FAIL rand_occ: count=%0d empty=%b full=%b expected %0d %b %b",
                         count, empty, full, exp_count, exp_empty, exp_full); end
            vectors++; if (alloc_ready !== exp_ready || alloc_tag !== 3'(exp_atag)) begin errors++;
                $display("FAIL rand_alloc: ready=%b tag=%0d expected %b %0d", alloc_ready, alloc_tag, exp_ready, exp_atag); end
            vectors++; if (commit_valid !== exp_cv || commit_tag !== 3'(exp_ctag) ||
                           commit_rd !== exp_crd || commit_data !== exp_cdata) begin errors++;
                $display("FAIL rand_commit: cv=%b tag=%0d rd=%0d data=%h expected %b %0d %0d %h",
                         commit_valid, commit_tag, commit_rd, commit_data, exp_cv, exp_ctag, exp_crd, exp_cdata); end
            vectors++; if (flush !== exp_flush || flush_pc !== exp_fpc) begin errors++;
                $display("FAIL rand_flush: flush=%b pc=%h expected %b %h", flush, flush_pc, exp_flush, exp_fpc); end
            vectors++; if (rs1_ready !== exp_r1 || rs1_data !== exp_d1 ||
                           rs2_ready !== exp_r2 || rs2_data !== exp_d2) begin errors++;
                $display("FAIL rand_lookup: r1=%b d1=%h r2=%b d2=%h expected %b %h %b %h",
                         rs1_ready, rs1_data, rs2_ready, rs2_data, exp_r1, exp_d1, exp_r2, exp_d2); end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fill_drain_wrap();
        test_dual_channel();
        test_bypass();
        test_flush();
        test_alloc_commit();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rob_mc.md
# rob_mc

Parametrised reorder buffer for the out-of-order RV32I core. It sits between the instruction queue/decoder and the regfile. It allocates one entry per dispatched instruction and accepts results from `NUM_CDB` independent broadcast channels per cycle (ALU, branch, LSQ). It retires in program order, one per cycle, and raises a one-cycle flush with a redirect PC when the retiring entry was mispredicted. It supersedes the fixed-size, single-broadcast ROB, adding configurable depth and channel count, operand lookup with same-cycle bypass, and recovery.

## Interface
Parameters:
- `WIDTH`, 32, data and PC width
- `DEPTH`, 8, entry count; must be a power of two and at least 2
- `NUM_CDB`, 2, number of result broadcast channels
- `TAG_W`, `$clog2(DEPTH)`, tag width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alloc_valid`  in  1  dispatch request
- `alloc_rd`  in  5  destination register; 0 means no writeback
- `alloc_pc`  in  WIDTH  PC of the instruction
- `alloc_ready`  out  1  allocation accepted this cycle
- `alloc_tag`  out  TAG_W  tag the next allocation receives (the tail index)
- `cdb_valid`  in  NUM_CDB  per-channel result strobe
- `cdb_tag`  in  NUM_CDB*TAG_W  packed tags; channel i is at bits [i*TAG_W +: TAG_W]
- `cdb_data`  in  NUM_CDB*WIDTH  packed results
- `cdb_mispredict`  in  NUM_CDB  result belongs to a mispredicted control-flow instruction
- `cdb_target`  in  NUM_CDB*WIDTH  correct next PC; meaningful only when the mispredict bit is set
- `rs1_tag`, `rs2_tag`  in  TAG_W each  operand lookup tags
- `rs1_ready`, `rs2_ready`  out  1 each  lookup value is available
- `rs1_data`, `rs2_data`  out  WIDTH each  lookup value
- `commit_valid`  out  1  head entry retires this cycle
- `commit_rd`  out  5  regfile destination
- `commit_data`  out  WIDTH  regfile write data
- `commit_tag`  out  TAG_W  tag of the retiring entry, so the regfile can clear its rename
- `flush`  out  1  pipeline flush
- `flush_pc`  out  WIDTH  redirect PC
- `count`  out  TAG_W+1  number of occupied entries
- `empty`  out  1  no entries occupied
- `full`  out  1  all entries occupied

## Operation
- **Entry state:** each entry holds `valid`, `done`, `mispredict`, `rd`, `data`, `pc` and `target`. Pointers are `head` and `tail` (TAG_W bits each, wrapping modulo DEPTH) plus `count`.
- **Allocation:**
  - `alloc_ready = !full && !flush`.
  - When `alloc_valid && alloc_ready`: entry[tail] gets valid=1, done=0, mispredict=0, rd and pc loaded; tail increments.
  - Allocation is refused when full, even if a commit occurs in the same cycle.
- **Broadcast:**
  - For each channel i with `cdb_valid[i]`, if entry[tag] is valid and not done: done=1, data, mispredict and target are written.
  - A broadcast to an invalid entry is ignored.
  - If two channels carry the same tag, the lowest channel index wins.
  - Broadcasts in a flush cycle are discarded.
- **Lookup:**
  - rsX_ready=1 with the stored data when entry[rsX_tag] is valid and done.
  - Otherwise, if any `cdb_valid[i]` matches the tag this cycle, rsX_ready=1 with that channel's data. When several channels match, the lowest index wins.
  - Otherwise rsX_ready=0 and rsX_data=0.
- **Commit:**
  - `commit_valid` = entry[head] valid && done, combinational.
  - `commit_rd`, `commit_data` and `commit_tag` come from the head entry and are 0 when commit_valid=0.
  - On commit, entry[head] valid is cleared and head increments.
- **Flush:**
  - `flush = commit_valid && entry[head].mispredict`; `flush_pc = entry[head].target`, else 0.
  - The mispredicting entry still commits. Its rd/data are valid, which covers the JAL/JALR link register.
  - At the edge ending a flush cycle: all entries are invalidated, head=tail=0 and count=0.
- **Count:** `count` is incremented on alloc and decremented on commit, with no change when both occur. `empty = (count==0)`, `full = (count==DEPTH)`.

## Timing
- **Reset:** head=tail=count=0 and all entries invalid. Outputs: alloc_ready=1, alloc_tag=0, empty=1, full=0, count=0, commit_valid=0, flush=0, flush_pc=0, rsX_ready=0.
- **Alloc:** alloc_tag is valid combinationally in cycle t. The entry is occupied from t+1.
- **Broadcast to commit:** a broadcast at edge t makes the head commit visible in cycle t+1. Minimum alloc-to-commit latency is 2 cycles.
- **Lookup bypass:** bypass is zero-cycle. A lookup in the same cycle as the broadcast returns the broadcast data.
- **Flush:** flush is high for exactly one cycle. The first allocation after a flush receives tag 0 in the following cycle.
- **Reset mid-operation:** all state clears immediately; no commit or flush is emitted.

## Test plan
- **Fill, drain and wrap (DEPTH=8, NUM_CDB=2):**
  - Stimulus: allocate 8 entries, then attempt a 9th.
  - Required: full=1, count=8, alloc_ready=0 and tail unchanged.
  - Stimulus: broadcast tags 7..0 in reverse order, two per cycle.
  - Required: commits emerge in tag order 0..7, one per cycle, starting the cycle after tag 0 is written.
  - Stimulus: allocate 8 more.
  - Required: tags wrap to 0..7.
- **Dual-channel same cycle:**
  - Stimulus: channel 0 sends tag 1 with 0xAAAA_0001; channel 1 sends tag 2 with 0xBBBB_0002.
  - Required: both entries are done in the next cycle and commit in consecutive cycles with the correct data.
- **Lookup bypass:**
  - Stimulus: rs1_tag=3 while channel 1 broadcasts tag 3 with 0x1234.
  - Required: rs1_ready=1 and rs1_data=0x1234 in that cycle; the stored value is returned thereafter.
- **Mispredict flush:**
  - Stimulus: 5 entries allocated; tag 0 completes with mispredict=1 and target=0x0000_0100; tags 1-4 are done.
  - Required: commit of tag 0 with flush=1 and flush_pc=0x100 in the same cycle.
  - Required next cycle: empty=1, count=0, alloc_tag=0, and tags 1-4 never commit.
- **Simultaneous alloc and commit:**
  - Stimulus: count=4; in one cycle, head commits and a new instruction allocates.
  - Required: count stays 4 and tail advances.
- **Async reset:**
  - Stimulus: assert rst mid-cycle with 6 entries occupied.
  - Required: outputs take their reset values immediately, without waiting for a clock edge.
